reg_fifo_stream_reader: RTL and testbench

Read-side engine for the register FIFOs in the DMA datapath. It drains a show-ahead register FIFO through its pop/empty/fifoDepth interface and presents the words on a registered valid/ready stream. A 2-entry output buffer means the downstream ready never combinationally drives the FIFO pop. An optional burst mode holds off draining until the FIFO reaches a fill threshold or a timeout expires, which batches DMA traffic.

---
 rtl/reg_fifo_stream_reader.sv | 150 +++++++++++++++
 tb/tb_reg_fifo_stream_reader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_fifo_stream_reader.sv
//------------------------------------------------------------------------------
// Module      : reg_fifo_stream_reader
// Description : Drains a show-ahead register FIFO into a registered
//               valid/ready stream through a 2-entry buffer, with optional
//               threshold/timeout burst gating.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_fifo_stream_reader #(
    parameter int DW      = 28,
    parameter int DEPTH_W = 3,
    parameter int TMO_W   = 8
) (
    input  logic               clockCore,
    input  logic               resetCore,
    input  logic               enable,
    input  logic               flush,
    input  logic               burstEn,
    input  logic [DEPTH_W-1:0] burstThreshold,
    input  logic [TMO_W-1:0]   timeoutCycles,
    input  logic [DW-1:0]      fifoDataOut,
    input  logic               fifoEmpty,
    input  logic [DEPTH_W-1:0] fifoDepth,
    output logic               fifoPop,
    output logic [DW-1:0]      outData,
    output logic               outValid,
    input  logic               outReady,
    input  logic               clrCount,
    output logic [15:0]        wordCount,
    output logic               busy
);

    localparam logic [1:0]       c_ST_IDLE      = 2'd0;
    localparam logic [1:0]       c_ST_WAIT_FILL = 2'd1;
    localparam logic [1:0]       c_ST_DRAIN     = 2'd2;
    localparam logic [TMO_W-1:0] c_TMO_ONE      = TMO_W'(1);

    logic [1:0]       r_state_q,      w_state_d;
    logic [1:0]       r_buf_cnt_q,    w_buf_cnt_d;
    logic [DW-1:0]    r_buf0_q,       w_buf0_d;
    logic [DW-1:0]    r_buf1_q,       w_buf1_d;
    logic [TMO_W-1:0] r_timer_q,      w_timer_d;
    logic [15:0]      r_word_count_q, w_word_count_d;

    logic w_push;
    logic w_accept;
    logic w_burst_go;

    // Pop depends only on registered state and FIFO flags, never on outReady.
    assign w_push   = (r_state_q == c_ST_DRAIN) & ~fifoEmpty & (r_buf_cnt_q < 2'd2) & ~flush;
    assign w_accept = (r_buf_cnt_q != 2'd0) & outReady;

    assign w_burst_go = ~fifoEmpty &
                        ((fifoDepth >= burstThreshold) |
                         ((timeoutCycles != '0) && (r_timer_q == timeoutCycles - c_TMO_ONE)));

    assign fifoPop   = w_push;
    assign outValid  = (r_buf_cnt_q != 2'd0);
    assign outData   = r_buf0_q;
    assign wordCount = r_word_count_q;
    assign busy      = (r_state_q != c_ST_IDLE) | (r_buf_cnt_q != 2'd0);

    always_comb begin
        w_state_d = r_state_q;
        w_timer_d = r_timer_q;
        if (flush || !enable) begin
            w_state_d = c_ST_IDLE;
            w_timer_d = '0;
        end else begin
            case (r_state_q)
                c_ST_IDLE: begin
                    w_state_d = burstEn ? c_ST_WAIT_FILL : c_ST_DRAIN;
                    w_timer_d = '0;
                end
                c_ST_WAIT_FILL: begin
                    if (w_burst_go) begin
                        w_state_d = c_ST_DRAIN;
                        w_timer_d = '0;
                    end else if (r_timer_q != '1) begin
                        w_timer_d = r_timer_q + c_TMO_ONE;
                    end
                end
                c_ST_DRAIN: begin
                    if (burstEn && fifoEmpty) begin
                        w_state_d = c_ST_WAIT_FILL;
                        w_timer_d = '0;
                    end
                end
                default: begin
                    w_state_d = c_ST_IDLE;
                    w_timer_d = '0;
                end
            endcase
        end
    end

    // Push and accept together only happen at bufCnt==1: the new word becomes the head.
    always_comb begin
        w_buf_cnt_d = r_buf_cnt_q;
        w_buf0_d    = r_buf0_q;
        w_buf1_d    = r_buf1_q;
        if (flush) begin
            w_buf_cnt_d = 2'd0;
        end else begin
            case ({w_push, w_accept})
                2'b10: begin
                    if (r_buf_cnt_q == 2'd0) w_buf0_d = fifoDataOut;
                    else                     w_buf1_d = fifoDataOut;
                    w_buf_cnt_d = r_buf_cnt_q + 2'd1;
                end
                2'b01: begin
                    w_buf0_d    = r_buf1_q;
                    w_buf_cnt_d = r_buf_cnt_q - 2'd1;
                end
                2'b11: begin
                    w_buf0_d = fifoDataOut;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_word_count_d = r_word_count_q;
        if (clrCount)      w_word_count_d = 16'd0;
        else if (w_accept) w_word_count_d = r_word_count_q + 16'd1;
    end

    always_ff @(posedge clockCore or negedge resetCore) begin
        if (!resetCore) begin
            r_state_q      <= c_ST_IDLE;
            r_buf_cnt_q    <= 2'd0;
            r_buf0_q       <= '0;
            r_buf1_q       <= '0;
            r_timer_q      <= '0;
            r_word_count_q <= 16'd0;
        end else begin
            r_state_q      <= w_state_d;
            r_buf_cnt_q    <= w_buf_cnt_d;
            r_buf0_q       <= w_buf0_d;
            r_buf1_q       <= w_buf1_d;
            r_timer_q      <= w_timer_d;
            r_word_count_q <= w_word_count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_fifo_stream_reader.sv
//------------------------------------------------------------------------------
// Module      : tb_reg_fifo_stream_reader
// Description : Directed and random bench for reg_fifo_stream_reader with a
//               show-ahead FIFO model and an in-order output scoreboard.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_fifo_stream_reader;

    localparam int DW      = 28;
    localparam int DEPTH_W = 3;
    localparam int TMO_W   = 8;
    localparam int C_CAP   = 7;

    logic               clockCore = 1'b0;
    logic               resetCore = 1'b1;
    logic               enable = 1'b0;
    logic               flush = 1'b0;
    logic               burstEn = 1'b0;
    logic [DEPTH_W-1:0] burstThreshold = '0;
    logic [TMO_W-1:0]   timeoutCycles = '0;
    logic [DW-1:0]      fifoDataOut = '0;
    logic               fifoEmpty = 1'b1;
    logic [DEPTH_W-1:0] fifoDepth = '0;
    logic               fifoPop;
    logic [DW-1:0]      outData;
    logic               outValid;
    logic               outReady = 1'b0;
    logic               clrCount = 1'b0;
    logic [15:0]        wordCount;
    logic               busy;

    logic               push_req = 1'b0;
    logic [DW-1:0]      push_data = '0;

    logic [DW-1:0]      fq[$];
    logic [DW-1:0]      exp_q[$];
    logic [DW-1:0]      e_word;
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 pop_cnt = 0;

    reg_fifo_stream_reader #(.DW(DW), .DEPTH_W(DEPTH_W), .TMO_W(TMO_W)) dut (
        .clockCore      (clockCore),
        .resetCore      (resetCore),
        .enable         (enable),
        .flush          (flush),
        .burstEn        (burstEn),
        .burstThreshold (burstThreshold),
        .timeoutCycles  (timeoutCycles),
        .fifoDataOut    (fifoDataOut),
        .fifoEmpty      (fifoEmpty),
        .fifoDepth      (fifoDepth),
        .fifoPop        (fifoPop),
        .outData        (outData),
        .outValid       (outValid),
        .outReady       (outReady),
        .clrCount       (clrCount),
        .wordCount      (wordCount),
        .busy           (busy)
    );

    always #5 clockCore = ~clockCore;

    // Show-ahead FIFO model; every accepted word is also queued as an expected output.
    always @(posedge clockCore or negedge resetCore) begin
        if (!resetCore) begin
            fq.delete();
            exp_q.delete();
        end else begin
            if (fifoPop && fq.size() > 0) e_word = fq.pop_front();
            if (push_req && fq.size() < C_CAP) begin
                fq.push_back(push_data);
                exp_q.push_back(push_data);
            end
        end
        fifoEmpty   <= (fq.size() == 0);
        fifoDataOut <= (fq.size() > 0) ? fq[0] : '0;
        fifoDepth   <= DEPTH_W'(fq.size());
    end

    always @(negedge clockCore) begin
        logic [DW-1:0] w_exp;
        if (resetCore) begin
            n_vec++;
            assert (!(fifoPop && fifoEmpty)) else begin
                n_err++;
                $error("FAIL pop_when_empty: observed pop=%0b empty=%0b required pop=0", fifoPop, fifoEmpty);
            end
            if (fifoPop) pop_cnt++;
            if (outValid && outReady) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $error("FAIL sb_extra_word: observed %0h required none", outData);
                end else begin
                    w_exp = exp_q.pop_front();
                    assert (outData === w_exp) else begin
                        n_err++;
                        $error("FAIL sb_data: observed %0h required %0h", outData, w_exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clockCore);
            #2;
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        push_req  = 1'b1;
        push_data = d;
        step();
        push_req  = 1'b0;
    endtask

    initial begin
        logic [7:0] pop_bits;
        logic [7:0] val_bits;
        int         first_pop;

        #1 resetCore = 1'b0;
        step(2);
        chk("rst_valid", {31'd0, outValid}, 32'd0);
        chk("rst_data", {4'd0, outData}, 32'd0);
        chk("rst_pop", {31'd0, fifoPop}, 32'd0);
        chk("rst_count", {16'd0, wordCount}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        resetCore = 1'b1;
        step();

        // 1: continuous drain at full rate
        outReady = 1'b1;
        for (int i = 1; i <= 4; i++) push_word(DW'(i));
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            pop_bits[i] = fifoPop;
            val_bits[i] = outValid;
        end
        chk("t1_pop_pattern", {24'd0, pop_bits}, 32'h0F);
        chk("t1_valid_pattern", {24'd0, val_bits}, 32'h1E);
        chk("t1_count", {16'd0, wordCount}, 32'd4);
        enable = 1'b0;
        step();
        chk("t1_busy_after", {31'd0, busy}, 32'd0);
        clrCount = 1'b1;
        step();
        clrCount = 1'b0;
        chk("t1_clr_count", {16'd0, wordCount}, 32'd0);

        // 2: backpressure holds two words, releases in order
        outReady = 1'b0;
        for (int i = 1; i <= 4; i++) push_word(DW'(i));
        pop_cnt = 0;
        enable  = 1'b1;
        step(6);
        chk("t2_pops_held", pop_cnt, 32'd2);
        chk("t2_pop_low", {31'd0, fifoPop}, 32'd0);
        chk("t2_data_held", {4'd0, outData}, 32'd1);
        chk("t2_valid_held", {31'd0, outValid}, 32'd1);
        chk("t2_depth", {29'd0, fifoDepth}, 32'd2);
        outReady = 1'b1;
        step(8);
        chk("t2_pops_total", pop_cnt, 32'd4);
        chk("t2_count", {16'd0, wordCount}, 32'd4);
        chk("t2_sb_empty", exp_q.size(), 32'd0);
        enable = 1'b0;
        step();

        // 3: threshold-gated burst, no timeout
        burstEn        = 1'b1;
        burstThreshold = 3'd3;
        timeoutCycles  = 8'd0;
        enable         = 1'b1;
        step(2);
        push_word(DW'('h10));
        push_word(DW'('h11));
        pop_cnt = 0;
        step(50);
        chk("t3_no_pop_below_thr", pop_cnt, 32'd0);
        chk("t3_depth_waiting", {29'd0, fifoDepth}, 32'd2);
        push_word(DW'('h12));
        step(10);
        chk("t3_burst_pops", pop_cnt, 32'd3);
        chk("t3_sb_empty", exp_q.size(), 32'd0);
        push_word(DW'('h13));
        step(10);
        chk("t3_rewait_no_pop", pop_cnt, 32'd3);
        chk("t3_busy_waiting", {31'd0, busy}, 32'd1);
        burstThreshold = 3'd0;
        step(5);
        chk("t3_thr0_pop", pop_cnt, 32'd4);
        chk("t3_thr0_sb_empty", exp_q.size(), 32'd0);
        enable = 1'b0;
        step();

        // 4: timeout releases a partial burst
        burstThreshold = 3'd4;
        timeoutCycles  = 8'd10;
        push_word(DW'('h20));
        enable    = 1'b1;
        first_pop = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (fifoPop && first_pop < 0) first_pop = i;
        end
        chk("t4_timeout_pop_cycle", first_pop, 32'd10);
        chk("t4_sb_empty", exp_q.size(), 32'd0);
        enable  = 1'b0;
        burstEn = 1'b0;
        step();

        // 5: flush with a full buffer drops the buffered words only
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) push_word(DW'('h30 + i));
        enable = 1'b1;
        step(5);
        chk("t5_buf_full_depth", {29'd0, fifoDepth}, 32'd1);
        flush = 1'b1;
        #1;
        chk("t5_no_pop_flush", {31'd0, fifoPop}, 32'd0);
        step();
        flush = 1'b0;
        chk("t5_valid_cleared", {31'd0, outValid}, 32'd0);
        chk("t5_idle_after_flush", {31'd0, busy}, 32'd0);
        e_word = exp_q.pop_front();
        e_word = exp_q.pop_front();
        outReady = 1'b1;
        step(6);
        chk("t5_sb_empty", exp_q.size(), 32'd0);
        chk("t5_fifo_drained", {29'd0, fifoDepth}, 32'd0);

        // 5b: flush gates a pop that would otherwise happen
        enable   = 1'b0;
        outReady = 1'b0;
        step();
        push_word(DW'('h40));
        push_word(DW'('h41));
        enable = 1'b1;
        step();
        chk("t5b_pop_armed", {31'd0, fifoPop}, 32'd1);
        flush = 1'b1;
        #1;
        chk("t5b_pop_gated", {31'd0, fifoPop}, 32'd0);
        step();
        flush = 1'b0;
        chk("t5b_no_capture", {31'd0, outValid}, 32'd0);
        outReady = 1'b1;
        step(6);
        chk("t5b_sb_empty", exp_q.size(), 32'd0);

        // 6: random traffic with an asynchronous reset in the middle
        for (int c = 0; c < 10000; c++) begin
            if (c == 5000) begin
                push_req = 1'b0;
                #1 resetCore = 1'b0;
                #1;
                chk("t6_rst_valid", {31'd0, outValid}, 32'd0);
                chk("t6_rst_data", {4'd0, outData}, 32'd0);
                chk("t6_rst_pop", {31'd0, fifoPop}, 32'd0);
                chk("t6_rst_count", {16'd0, wordCount}, 32'd0);
                chk("t6_rst_busy", {31'd0, busy}, 32'd0);
                step(3);
                resetCore = 1'b1;
            end
            push_req  = ($urandom_range(0, 99) < 45);
            push_data = DW'($urandom);
            outReady  = ($urandom_range(0, 99) < 60);
            step();
        end
        push_req = 1'b0;
        outReady = 1'b1;
        step(20);
        chk("t6_sb_empty", exp_q.size(), 32'd0);
        chk("t6_fifo_empty", {29'd0, fifoDepth}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
